// File: rtl/reset_sequencer.sv
// Multi-domain reset sequencer: filters PLL lock, then releases active-low
// channel resets in ascending order, re-asserting all on lock loss or soft request.
module reset_sequencer #(
    parameter int unsigned NUM_CH         = 3,
    parameter int unsigned STEP_DELAY_CC  = 50000,
    parameter int unsigned LOCK_FILTER_CC = 1024
) (
    input  logic              piul1Clock,
    input  logic              piul1Reset,
    input  logic              piul1Locked,
    input  logic              piul1ResetReq,
    output logic [NUM_CH-1:0] poulNReset_n,
    output logic              poul1Ready,
    output logic [1:0]        poul2State,
    output logic [7:0]        poul8LockLossCount
);

    localparam int unsigned FILT_W = $clog2((LOCK_FILTER_CC < 2) ? 2 : LOCK_FILTER_CC);
    localparam int unsigned STEP_W = $clog2((STEP_DELAY_CC < 2) ? 2 : STEP_DELAY_CC);
    localparam int unsigned IDX_W  = $clog2((NUM_CH < 2) ? 2 : NUM_CH);

    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILTER_CC - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DELAY_CC - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } seqState_t;

    seqState_t         seqState;
    logic              ul1LockMeta;
    logic              ul1LockS;
    logic [FILT_W-1:0] filtCnt;
    logic [STEP_W-1:0] stepCnt;
    logic [IDX_W-1:0]  chIdx;

    // Two-flop synchroniser for the asynchronous PLL lock
    always_ff @(posedge piul1Clock or posedge piul1Reset) begin
        if (piul1Reset) begin
            ul1LockMeta <= 1'b0;
            ul1LockS    <= 1'b0;
        end else begin
            ul1LockMeta <= piul1Locked;
            ul1LockS    <= ul1LockMeta;
        end
    end

    // Sequencer FSM with registered outputs
    always_ff @(posedge piul1Clock or posedge piul1Reset) begin
        if (piul1Reset) begin
            seqState           <= HOLD;
            filtCnt            <= '0;
            stepCnt            <= '0;
            chIdx              <= '0;
            poulNReset_n       <= '0;
            poul1Ready         <= 1'b0;
            poul8LockLossCount <= 8'd0;
        end else begin
            case (seqState)
                HOLD: begin
                    if (!ul1LockS || piul1ResetReq) begin
                        filtCnt <= '0;
                    end else if (filtCnt == FILT_LAST) begin
                        seqState <= RELEASE;
                        filtCnt  <= '0;
                        stepCnt  <= '0;
                        chIdx    <= '0;
                    end else begin
                        filtCnt <= filtCnt + FILT_W'(1);
                    end
                end
                RELEASE, RUN: begin
                    if (!ul1LockS || piul1ResetReq) begin
                        // Abort: simultaneous loss and request count once
                        seqState     <= HOLD;
                        filtCnt      <= '0;
                        stepCnt      <= '0;
                        chIdx        <= '0;
                        poulNReset_n <= '0;
                        poul1Ready   <= 1'b0;
                        if (!ul1LockS && (poul8LockLossCount != 8'hFF)) begin
                            poul8LockLossCount <= poul8LockLossCount + 8'd1;
                        end
                    end else if (seqState == RELEASE) begin
                        if (stepCnt == STEP_LAST) begin
                            poulNReset_n <= poulNReset_n | (NUM_CH'(1) << chIdx);
                            stepCnt      <= '0;
                            if (chIdx == IDX_LAST) begin
                                seqState   <= RUN;
                                poul1Ready <= 1'b1;
                            end else begin
                                chIdx <= chIdx + IDX_W'(1);
                            end
                        end else begin
                            stepCnt <= stepCnt + STEP_W'(1);
                        end
                    end
                end
                default: begin
                    seqState <= HOLD;
                end
            endcase
        end
    end

    assign poul2State = seqState;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with NUM_CH=3, STEP=4, FILTER=8.
module tb_reset_sequencer;

    logic       clk;
    logic       rst;
    logic       locked;
    logic       req;
    logic [2:0] rstN;
    logic       ready;
    logic [1:0] state;
    logic [7:0] lossCnt;

    int errors;
    int checks;
    int edgeN;

    reset_sequencer #(
        .NUM_CH        (3),
        .STEP_DELAY_CC (4),
        .LOCK_FILTER_CC(8)
    ) dut (
        .piul1Clock        (clk),
        .piul1Reset        (rst),
        .piul1Locked       (locked),
        .piul1ResetReq     (req),
        .poulNReset_n      (rstN),
        .poul1Ready        (ready),
        .poul2State        (state),
        .poul8LockLossCount(lossCnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected {Reset_n[2:0], Ready, State} when RELEASE is entered at edge relEdge
    function automatic logic [5:0] expVec(input int e, input int relEdge);
        logic [2:0] r;
        logic       rdy;
        logic [1:0] st;
        r = 3'b000;
        for (int k = 0; k < 3; k++) begin
            if (e >= relEdge + 4 * (k + 1)) r[k] = 1'b1;
        end
        rdy = (e >= relEdge + 12);
        st  = (e < relEdge) ? 2'd0 : (rdy ? 2'd2 : 2'd1);
        return {r, rdy, st};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        edgeN++;
    endtask

    // After this, the next posedge is edge 1
    task automatic doReset();
        rst = 1'b1;
        req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst   = 1'b0;
        edgeN = 0;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        locked = 1'b1;
        req    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (rstN !== 3'b000) begin errors++; $display("FAIL reset_rstN: got %b expected 000", rstN); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
        checks++; if (lossCnt !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", lossCnt); end
    endtask

    task automatic test_sequence();
        logic [5:0] exp;
        locked = 1'b1;
        doReset();
        for (int e = 1; e <= 26; e++) begin
            tick();
            exp = expVec(edgeN, 10);
            checks++;
            if ({rstN, ready, state} !== exp) begin
                errors++;
                $display("FAIL seq edge %0d: got %b expected %b", edgeN, {rstN, ready, state}, exp);
            end
        end
        checks++; if (lossCnt !== 8'd0) begin errors++; $display("FAIL seq_count: got %0d expected 0", lossCnt); end
    endtask

    task automatic test_glitch();
        logic [5:0] exp;
        locked = 1'b1;
        doReset();
        for (int e = 1; e <= 32; e++) begin
            locked = (edgeN == 5) ? 1'b0 : 1'b1;
            tick();
            exp = expVec(edgeN, 16);
            checks++;
            if ({rstN, ready, state} !== exp) begin
                errors++;
                $display("FAIL glitch edge %0d: got %b expected %b", edgeN, {rstN, ready, state}, exp);
            end
        end
        checks++; if (lossCnt !== 8'd0) begin errors++; $display("FAIL glitch_count: got %0d expected 0", lossCnt); end
    endtask

    task automatic test_lock_loss();
        logic [5:0] exp;
        locked = 1'b1;
        doReset();
        while (edgeN < 22) tick();
        locked = 1'b0;
        tick();
        tick();
        checks++;
        if ({rstN, ready, state} !== 6'b111_1_10) begin
            errors++;
            $display("FAIL loss_before_abort: got %b expected 111110", {rstN, ready, state});
        end
        tick();
        checks++;
        if ({rstN, ready, state} !== 6'b000_0_00) begin
            errors++;
            $display("FAIL loss_abort: got %b expected 000000", {rstN, ready, state});
        end
        checks++; if (lossCnt !== 8'd1) begin errors++; $display("FAIL loss_count: got %0d expected 1", lossCnt); end
        locked = 1'b1;
        for (int e = 26; e <= 50; e++) begin
            tick();
            exp = expVec(edgeN, 35);
            checks++;
            if ({rstN, ready, state} !== exp) begin
                errors++;
                $display("FAIL relock edge %0d: got %b expected %b", edgeN, {rstN, ready, state}, exp);
            end
        end
        checks++; if (lossCnt !== 8'd1) begin errors++; $display("FAIL relock_count: got %0d expected 1", lossCnt); end
    endtask

    task automatic test_soft_req();
        logic [5:0] exp;
        locked = 1'b1;
        doReset();
        while (edgeN < 15) tick();
        checks++;
        if (rstN !== 3'b001) begin errors++; $display("FAIL req_pre: got %b expected 001", rstN); end
        req = 1'b1;
        for (int e = 16; e <= 20; e++) begin
            tick();
            checks++;
            if ({rstN, ready, state} !== 6'b000_0_00) begin
                errors++;
                $display("FAIL req_hold edge %0d: got %b expected 000000", edgeN, {rstN, ready, state});
            end
        end
        req = 1'b0;
        for (int e = 21; e <= 42; e++) begin
            tick();
            exp = expVec(edgeN, 28);
            checks++;
            if ({rstN, ready, state} !== exp) begin
                errors++;
                $display("FAIL req_restart edge %0d: got %b expected %b", edgeN, {rstN, ready, state}, exp);
            end
        end
        checks++; if (lossCnt !== 8'd0) begin errors++; $display("FAIL req_count: got %0d expected 0", lossCnt); end
    endtask

    task automatic test_loss_and_req();
        locked = 1'b1;
        doReset();
        while (edgeN < 22) tick();
        locked = 1'b0;
        tick();
        tick();
        req = 1'b1;
        tick();
        req = 1'b0;
        checks++;
        if ({rstN, ready, state} !== 6'b000_0_00) begin
            errors++;
            $display("FAIL both_abort: got %b expected 000000", {rstN, ready, state});
        end
        checks++; if (lossCnt !== 8'd1) begin errors++; $display("FAIL both_count: got %0d expected 1", lossCnt); end
    endtask

    task automatic test_async_reset();
        logic [5:0] exp;
        locked = 1'b1;
        doReset();
        while (edgeN < 16) tick();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({rstN, ready, state, lossCnt} !== 14'd0) begin
            errors++;
            $display("FAIL async_reset: got %b expected all zero", {rstN, ready, state, lossCnt});
        end
        @(posedge clk);
        #1;
        rst   = 1'b0;
        edgeN = 0;
        for (int e = 1; e <= 24; e++) begin
            tick();
            exp = expVec(edgeN, 10);
            checks++;
            if ({rstN, ready, state} !== exp) begin
                errors++;
                $display("FAIL async_restart edge %0d: got %b expected %b", edgeN, {rstN, ready, state}, exp);
            end
        end
    endtask

    task automatic test_saturation();
        int  budget;
        int  expCnt;
        bit  abortRun;
        locked   = 1'b1;
        abortRun = 1'b0;
        doReset();
        for (int n = 1; n <= 300 && !abortRun; n++) begin
            budget = 0;
            while (ready !== 1'b1 && budget < 40) begin tick(); budget++; end
            if (ready !== 1'b1) begin
                checks++; errors++; abortRun = 1'b1;
                $display("FAIL sat_wait_ready loss %0d: ready=%b expected 1", n, ready);
            end else begin
                locked = 1'b0;
                budget = 0;
                while (state !== 2'd0 && budget < 6) begin tick(); budget++; end
                locked = 1'b1;
                if (state !== 2'd0) begin
                    checks++; errors++; abortRun = 1'b1;
                    $display("FAIL sat_wait_hold loss %0d: state=%0d expected 0", n, state);
                end else if (n == 1 || n == 254 || n == 255 || n == 256 || n == 300) begin
                    expCnt = (n < 255) ? n : 255;
                    checks++;
                    if (lossCnt !== 8'(expCnt)) begin
                        errors++;
                        $display("FAIL sat_count loss %0d: got %0d expected %0d", n, lossCnt, expCnt);
                    end
                end
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        edgeN  = 0;
        rst    = 1'b1;
        locked = 1'b0;
        req    = 1'b0;
        test_reset();
        test_sequence();
        test_glitch();
        test_lock_loss();
        test_soft_req();
        test_loss_and_req();
        test_async_reset();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
